// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - oversampling 8N1 UART receiver with byte handshake and error flags
module uart_rx_deser #(
    parameter logic [7:0] PERIOD = 8'h0C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxin,
    input  logic       rd_ack,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic [7:0] div;
    logic [3:0] scnt;
    logic [2:0] bitcnt;
    logic [7:0] sreg;
    logic       s7, s8, s9;
    logic       tick;
    logic       data_vote;
    logic       stop_vote;
    logic       start_det;
    logic       commit;

    assign tick      = (div == PERIOD - 8'd1);
    assign data_vote = (s7 & s8) | (s7 & s9) | (s8 & s9);
    // Stop bit commits on the third sample tick itself, so the live rx_s stands in for s9.
    assign stop_vote = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign start_det = (state == IDLE) && !rx_s;
    assign commit    = (state == STOP) && tick && (scnt == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxin;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= 8'd0;
            scnt <= 4'd0;
            s7   <= 1'b1;
            s8   <= 1'b1;
            s9   <= 1'b1;
        end else if (start_det) begin
            div  <= 8'd0;
            scnt <= 4'd0;
        end else begin
            div <= tick ? 8'd0 : div + 8'd1;
            if (tick) begin
                scnt <= scnt + 4'd1;
                case (scnt)
                    4'd7:    s7 <= rx_s;
                    4'd8:    s8 <= rx_s;
                    4'd9:    s9 <= rx_s;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            sreg      <= 8'd0;
            dout      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (rd_ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt == 4'd7 && rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (scnt == 4'd15) begin
                            state  <= DATA;
                            bitcnt <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (tick && scnt == 4'd15) begin
                        sreg   <= {data_vote, sreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives a back-to-back start bit time to be seen.
                    if (commit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!valid || rd_ack) begin
                            dout      <= sreg;
                            frame_err <= ~stop_vote;
                            valid     <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - directed frames against an event-level receiver model
module tb_uart_rx_deser;
    localparam int P   = 12;
    localparam int BIT = 16 * P;
    // rxin fall -> 3 edges to start detect, then commit on stop-bit tick 9 (tick index 153).
    localparam int LAT = 3 + 154 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxin = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] m_dout = 8'd0;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ov = 1'b0;
    logic       had;
    logic       eb;
    int         pend_cyc = 0;
    logic [7:0] pend_data = 8'd0;
    logic       pend_ferr = 1'b0;
    logic       pend_active = 1'b0;
    int         b_start = 0, b_end = 0, b2_start = 0, b2_end = 0;

    uart_rx_deser #(.PERIOD(8'h0C)) dut (
        .clk(clk),
        .reset(reset),
        .rxin(rxin),
        .rd_ack(rd_ack),
        .dout(dout),
        .valid(valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: byte delivered at the commit cycle, handshake applied at every edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_dout = 8'd0; m_valid = 1'b0; m_ferr = 1'b0; m_ov = 1'b0;
            pend_active = 1'b0; b_end = 0; b2_end = 0;
        end else begin
            had = m_valid;
            if (rd_ack && had) begin
                m_valid = 1'b0;
                m_ov    = 1'b0;
            end
            if (pend_active && cyc == pend_cyc) begin
                pend_active = 1'b0;
                if (!had || rd_ack) begin
                    m_dout = pend_data; m_ferr = pend_ferr; m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        eb = !reset && ((cyc >= b_start && cyc < b_end) || (cyc >= b2_start && cyc < b2_end));
        chk8("dout", dout, reset ? 8'h00 : m_dout);
        chk1("valid", valid, reset ? 1'b0 : m_valid);
        chk1("frame_err", frame_err, reset ? 1'b0 : m_ferr);
        chk1("overrun", overrun, reset ? 1'b0 : m_ov);
        chk1("busy", busy, eb);
    end

    task automatic send_frame(input logic [7:0] data, input logic stop, input int g_off,
                              input int abort_off, input logic ack_commit);
        logic [9:0] bits;
        int c0;
        bits = {stop, data, 1'b0};
        @(posedge clk); #1;
        c0 = cyc;
        pend_cyc = c0 + LAT; pend_data = data; pend_ferr = ~stop; pend_active = 1'b1;
        b_start = c0 + 3; b_end = c0 + LAT;
        if (!stop) begin
            // Stop still low after commit: start re-detected, then rejected at mid-bit.
            b2_start = c0 + LAT + 1; b2_end = c0 + LAT + 1 + 8 * P;
        end
        for (int k = 0; k < 10 * BIT; k++) begin
            if (k == abort_off) begin
                reset = 1'b1; rxin = 1'b1; rd_ack = 1'b0;
                return;
            end
            rxin = bits[k / BIT];
            if (k == g_off) rxin = 1'b0;
            rd_ack = ack_commit && (k == LAT - 1);
            @(posedge clk); #1;
        end
        rxin = 1'b1;
        rd_ack = 1'b0;
    endtask

    task automatic low_pulse(input int n);
        @(posedge clk); #1;
        b_start = cyc + 3; b_end = cyc + 3 + 8 * P;
        rxin = 1'b0;
        repeat (n) @(posedge clk);
        #1 rxin = 1'b1;
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 rd_ack = 1'b1;
        @(posedge clk); #1 rd_ack = 1'b0;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk8("rst_dout", dout, 8'h00);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        send_frame(8'h55, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk8("t1_dout", dout, 8'h55);
        chk1("t1_valid", valid, 1'b1);
        chk1("t1_ferr", frame_err, 1'b0);
        chk1("t1_busy", busy, 1'b0);
        ack_pulse();
        @(negedge clk);
        chk1("t1_ack_valid", valid, 1'b0);

        send_frame(8'hA3, 1'b1, -1, -1, 1'b0);
        send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk8("t2_dout", dout, 8'hA3);
        chk1("t2_overrun", overrun, 1'b1);
        ack_pulse();
        @(negedge clk);
        chk1("t2_ack_valid", valid, 1'b0);
        chk1("t2_ack_overrun", overrun, 1'b0);

        low_pulse(60);
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk1("t3_valid", valid, 1'b0);
        chk1("t3_busy", busy, 1'b0);
        chk8("t3_dout", dout, 8'hA3);

        send_frame(8'h81, 1'b0, -1, -1, 1'b0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk8("t4_dout", dout, 8'h81);
        chk1("t4_ferr", frame_err, 1'b1);
        chk1("t4_valid", valid, 1'b1);
        ack_pulse();

        send_frame(8'hFF, 1'b1, 4 * BIT + 108, -1, 1'b0);
        @(negedge clk);
        chk8("t5_dout", dout, 8'hFF);
        chk1("t5_ferr", frame_err, 1'b0);

        send_frame(8'hC6, 1'b1, -1, 5 * BIT + 40, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk8("t6_rst_dout", dout, 8'h00);
        chk1("t6_rst_valid", valid, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        send_frame(8'h42, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk8("t6_dout", dout, 8'h42);
        chk1("t6_valid", valid, 1'b1);
        send_frame(8'h17, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk1("t6_overrun", overrun, 1'b1);
        chk8("t6_kept", dout, 8'h42);
        send_frame(8'h5A, 1'b1, -1, -1, 1'b1);
        @(negedge clk);
        chk1("t6_same_valid", valid, 1'b1);
        chk8("t6_same_dout", dout, 8'h5A);
        chk1("t6_same_overrun", overrun, 1'b0);
        ack_pulse();
        @(negedge clk);
        chk1("t6_final_valid", valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
